// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller: frame-synchronous value update,
// leading-zero blanking, per-digit decimal points and PWM brightness.
module ssd_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 10000,
  parameter int BRIGHT_W    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int PHASES = 1 << BRIGHT_W;
  localparam int SLICE  = REFRESH_DIV / PHASES;
  localparam int SW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int LW     = (SLICE > 1) ? $clog2(SLICE) : 1;
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [LW-1:0] SLICE_LAST = LW'(SLICE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [SW-1:0]         slot_q, slot_d;
  logic [LW-1:0]         slice_q, slice_d;
  logic [BRIGHT_W-1:0]   phase_q, phase_d;
  logic [IW-1:0]         index_q, index_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  tick_q, tick_d;

  logic                  slot_end;
  logic                  slice_end;
  logic                  frame_start;
  logic                  lit;
  logic [3:0]            nibble;
  logic [DIGITS-1:0]     blank_vec;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A digit is blanked when it and every more-significant nibble are zero.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_first
        assign blank_vec[gi] = 1'b0;
      end else begin : g_rest
        assign blank_vec[gi] = blank_lz && (disp_q[4*DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

  assign slot_end    = (slot_q == SLOT_LAST);
  assign slice_end   = (slice_q == SLICE_LAST);
  assign frame_start = slot_end && (index_q == IDX_LAST);
  assign lit         = (phase_q <= bright);
  assign nibble      = disp_q[4*index_q +: 4];

  always_comb begin
    slot_d   = slot_end ? '0 : slot_q + 1'b1;
    slice_d  = (slot_end || slice_end) ? '0 : slice_q + 1'b1;
    phase_d  = phase_q;
    if (slot_end)
      phase_d = '0;
    else if (slice_end)
      phase_d = phase_q + 1'b1;
    index_d  = index_q;
    if (slot_end)
      index_d = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
    shadow_d = load ? value : shadow_q;
    // Display takes the pre-load shadow even when load coincides with frame start.
    disp_d   = frame_start ? shadow_q : disp_q;
    tick_d   = frame_start;

    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d = ~(DIGITS'(1) << index_q);
      dp_d = ~dp_mask[index_q];
      if (!blank_vec[index_q])
        seg_d = hex2seg(nibble);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q   <= '0;
      slice_q  <= '0;
      phase_q  <= '0;
      index_q  <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      slice_q  <= slice_d;
      phase_q  <= phase_d;
      index_q  <= index_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      tick_q   <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: directed scenarios plus random traffic, every output
// compared each cycle against a cycle-count based model of the display.
module tb_ssd_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [1:0]  bright;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  // Model state: cycles since reset release, shadow and shown value.
  int          c = 0;
  logic [15:0] shadow_m = 16'h0;
  logic [15:0] disp_m = 16'h0;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  ssd_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(8), .BRIGHT_W(2)) dut (
    .clock(clock), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
    .dp_mask(dp_mask), .bright(bright), .an(an), .seg(seg), .dp(dp),
    .frame_tick(frame_tick)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  // 8 cycles per digit, 2 cycles per brightness phase, 32 cycles per frame.
  function automatic void model_out(input int cc, input logic [15:0] d, input logic bl,
                                    input logic [3:0] dm, input logic [1:0] br,
                                    output logic [3:0] e_an, output logic [6:0] e_seg,
                                    output logic e_dp);
    int idx;
    int ph;
    logic [15:0] upper;
    idx = (cc / 8) % 4;
    ph  = (cc % 8) / 2;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (ph <= int'(br)) begin
      e_an  = 4'hF & ~(4'(1) << idx);
      e_dp  = ~dm[idx];
      upper = d >> (4 * idx);
      if (!(bl && idx > 0 && upper == 16'h0))
        e_seg = dec_tab[d[4*idx +: 4]];
    end
  endfunction

  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_ft;
    model_out(c, disp_m, blank_lz, dp_mask, bright, e_an, e_seg, e_dp);
    e_ft = (c % 32 == 31);
    @(posedge clock);
    if (c % 32 == 31) disp_m = shadow_m;
    if (load) shadow_m = value;
    c++;
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_value(input logic [15:0] v);
    value = v; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_ft"}, 32'(frame_tick), 32'h0);
  endtask

  initial begin
    reset = 1'b1; value = '0; load = 1'b0; blank_lz = 1'b0; dp_mask = '0; bright = 2'd3;
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    c = 0; shadow_m = '0; disp_m = '0;
    $display("txn reset_release checks=%0d errors=%0d", checks, errors);

    load_value(16'h12AF);
    steps(100);
    $display("txn show_12AF checks=%0d errors=%0d", checks, errors);

    blank_lz = 1'b1;
    load_value(16'h0030);
    steps(80);
    blank_lz = 1'b0;
    steps(40);
    $display("txn blank_0030 checks=%0d errors=%0d", checks, errors);

    load_value(16'h8888);
    bright = 2'd0; steps(64);
    bright = 2'd1; steps(32);
    bright = 2'd3; steps(32);
    $display("txn brightness_8888 checks=%0d errors=%0d", checks, errors);

    while (c % 32 != 0) step();
    chk("tick_align", 32'(frame_tick), 32'h1);
    load_value(16'h1111);
    steps(70);
    $display("txn load_on_tick checks=%0d errors=%0d", checks, errors);

    dp_mask = 4'b0100; blank_lz = 1'b1;
    load_value(16'h0000);
    steps(70);
    $display("txn dp_survives_blank checks=%0d errors=%0d", checks, errors);

    dp_mask = 4'b0000; bright = 2'd3;
    while (c % 32 != 19) step();
    chk("pre_reset_an", 32'(an), 32'hB);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(posedge clock);
    #1;
    chk_reset_outputs("held_reset");
    reset = 1'b0;
    c = 0; shadow_m = '0; disp_m = '0;
    steps(40);
    $display("txn reset_mid_slot checks=%0d errors=%0d", checks, errors);

    for (int i = 0; i < 800; i++) begin
      load = ($urandom_range(0, 7) == 0);
      value = 16'($urandom) & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                              {4{$urandom_range(0, 1) == 1}}, 4'hF};
      if (i % 16 == 0) begin
        bright   = 2'($urandom_range(0, 3));
        blank_lz = 1'($urandom_range(0, 1));
        dp_mask  = 4'($urandom);
      end
      step();
    end
    load = 1'b0;
    $display("txn random_traffic checks=%0d errors=%0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
